alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 The module SHALL have port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have ports i_req0_valid / i_req1_valid, input, 1, requester N presents an operation.
REQ-005 The module SHALL have ports o_req0_ready / o_req1_ready, output, 1, operation of requester N accepted this cycle.
REQ-006 The module SHALL have ports i_req0_r, i_req0_s, i_req1_r, i_req1_s, input, 32, ALU r/s operands per requester.
REQ-007 The module SHALL have ports i_req0_aluc / i_req1_aluc, input, 4, ALU control code per requester (`ALU_* macro encoding).
REQ-008 The module SHALL have ports o_rsp0_valid / o_rsp1_valid, output, 1, result for requester N held valid.
REQ-009 The module SHALL have ports i_rsp0_ready / i_rsp1_ready, input, 1, requester N consumes its result.
REQ-010 The module SHALL have port o_rsp_data, output, 32, registered ALU result (meaningful only with an o_rspN_valid).
REQ-011 The module SHALL have ports o_alu_r, o_alu_s (output, 32) and o_alu_aluc (output, 4), driving the shared combinational ALU.
REQ-012 The module SHALL have port i_alu, input, 32, shared ALU result.
REQ-013 The module SHALL have port o_busy, output, 1, high while a result is held.
REQ-014 The module SHALL have port o_op_cnt, output, CNT_W, count of completed (consumed) operations.

Function
REQ-015 The module SHALL implement two states: IDLE (no result held) and HOLD (result held for owner, owner bit recorded).
REQ-016 A grant SHALL be possible in IDLE, or in HOLD in the same cycle the owner's i_rspN_ready is high (back-to-back).
REQ-017 When a grant is possible and exactly one i_reqN_valid is high, that requester SHALL be granted.
REQ-018 When both are valid, the requester indicated by the round-robin pointer SHALL be granted; pointer resets to 0.
REQ-019 After every grant the pointer SHALL move to the non-granted requester.
REQ-020 o_reqN_ready SHALL be high only for the granted requester, combinationally, in the grant cycle; never for both.
REQ-021 In a grant cycle o_alu_r/o_alu_s/o_alu_aluc SHALL equal the granted requester's operands; otherwise all zero.
REQ-022 On a grant edge i_alu SHALL be captured into o_rsp_data, owner recorded, state -> HOLD; latency one cycle from accept to o_rspN_valid.
REQ-023 In HOLD, o_rspN_valid SHALL be high for the owner only; o_rsp_data and owner SHALL remain stable until consumed.
REQ-024 On consume without a new grant, state SHALL return to IDLE and o_rspN_valid SHALL drop next cycle.
REQ-025 i_rspN_ready of the non-owner SHALL be ignored; i_rspN_ready in IDLE SHALL be ignored.
REQ-026 o_busy SHALL equal (state == HOLD).
REQ-027 o_op_cnt SHALL increment by 1 on each consume edge, wrapping from 2^CNT_W-1 to 0.
REQ-028 Requests not granted SHALL receive no ready; requesters hold valid and operands until ready (no internal request queue).

Reset
REQ-029 Asserting i_rst at any time SHALL immediately force IDLE, pointer 0, o_rsp_data 0, o_op_cnt 0, all o_rspN_valid 0.
REQ-030 An operation held at reset SHALL be discarded; its requester SHALL reissue it.
REQ-031 During reset o_reqN_ready SHALL be 0 and ALU drive outputs 0.

Verification
REQ-032 Single: req0 ADD r=5 s=7, rsp0_ready=1 -> ready0 same cycle, next cycle rsp0_valid=1, data=12, op_cnt=1.
REQ-033 Contention: both valid from reset (req0 SUB 10-3, req1 OR 0xF0|0x0F), rsp ready high -> req0 first (data 7), then req1 (data 0xFF), grants on consecutive cycles.
REQ-034 Backpressure: rsp0_ready=0 for 4 cycles with result 0x1234 held -> rsp0_valid and data stable, no new ready, o_busy=1; on ready -> consume, op_cnt+1.
REQ-035 Fairness: both valid continuously for 8 grants -> grants strictly alternate 0,1,0,1...
REQ-036 Reset mid-HOLD: assert i_rst while rsp1_valid=1 -> rsp1_valid, o_busy, o_op_cnt drop to 0 asynchronously, pointer back to 0.
REQ-037 Wrap: CNT_W=4, 16 consumes -> o_op_cnt returns to 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One result is registered and held for its owner until consumed.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  input  logic             i_req1_valid,
  output logic             o_req0_ready,
  output logic             o_req1_ready,
  input  logic [31:0]      i_req0_r,
  input  logic [31:0]      i_req0_s,
  input  logic [31:0]      i_req1_r,
  input  logic [31:0]      i_req1_s,
  input  logic [3:0]       i_req0_aluc,
  input  logic [3:0]       i_req1_aluc,
  output logic             o_rsp0_valid,
  output logic             o_rsp1_valid,
  input  logic             i_rsp0_ready,
  input  logic             i_rsp1_ready,
  output logic [31:0]      o_rsp_data,
  output logic [31:0]      o_alu_r,
  output logic [31:0]      o_alu_s,
  output logic [3:0]       o_alu_aluc,
  input  logic [31:0]      i_alu,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_op_cnt
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_next;
  logic             owner, owner_next;
  logic             ptr, ptr_next;
  logic [31:0]      rsp_data;
  logic [CNT_W-1:0] op_cnt;

  logic consume;
  logic grant_ok;
  logic grant0;
  logic grant1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      ptr      <= 1'b0;
      rsp_data <= 32'd0;
      op_cnt   <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      ptr   <= ptr_next;
      if (grant0 || grant1) begin
        rsp_data <= i_alu;
      end
      if (consume) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    ptr_next     = ptr;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_alu_r      = 32'd0;
    o_alu_s      = 32'd0;
    o_alu_aluc   = 4'd0;

    // Only the owner's ready can free the slot; the other side is ignored.
    consume  = (state == HOLD) && (owner ? i_rsp1_ready : i_rsp0_ready);
    grant_ok = (state == IDLE) || consume;
    grant0   = grant_ok && i_req0_valid && (!i_req1_valid || !ptr);
    grant1   = grant_ok && i_req1_valid && (!i_req0_valid || ptr);

    if (grant0) begin
      state_next = HOLD;
      owner_next = 1'b0;
      ptr_next   = 1'b1;
    end else if (grant1) begin
      state_next = HOLD;
      owner_next = 1'b1;
      ptr_next   = 1'b0;
    end else if (consume) begin
      state_next = IDLE;
    end

    // Reset gates only the combinational outputs, keeping it off the flop data paths.
    if (!i_rst) begin
      if (grant0) begin
        o_req0_ready = 1'b1;
        o_alu_r      = i_req0_r;
        o_alu_s      = i_req0_s;
        o_alu_aluc   = i_req0_aluc;
      end else if (grant1) begin
        o_req1_ready = 1'b1;
        o_alu_r      = i_req1_r;
        o_alu_s      = i_req1_s;
        o_alu_aluc   = i_req1_aluc;
      end
    end
  end

  assign o_rsp0_valid = (state == HOLD) && !owner;
  assign o_rsp1_valid = (state == HOLD) && owner;
  assign o_busy       = (state == HOLD);
  assign o_rsp_data   = rsp_data;
  assign o_op_cnt     = op_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: fixed vectors, corner sequences and random traffic
// against a transaction-level model of the arbitration rules.
module tb_alu_arbiter;

  localparam int CW = 4;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req0_valid, i_req1_valid;
  logic          o_req0_ready, o_req1_ready;
  logic [31:0]   i_req0_r, i_req0_s, i_req1_r, i_req1_s;
  logic [3:0]    i_req0_aluc, i_req1_aluc;
  logic          o_rsp0_valid, o_rsp1_valid;
  logic          i_rsp0_ready, i_rsp1_ready;
  logic [31:0]   o_rsp_data;
  logic [31:0]   o_alu_r, o_alu_s;
  logic [3:0]    o_alu_aluc;
  logic [31:0]   i_alu;
  logic          o_busy;
  logic [CW-1:0] o_op_cnt;

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] r, input logic [31:0] s,
                                         input logic [3:0] c);
    case (c)
      ALU_ADD: return r + s;
      ALU_SUB: return r - s;
      ALU_AND: return r & s;
      ALU_OR:  return r | s;
      ALU_XOR: return r ^ s;
      ALU_SLL: return r << s[4:0];
      ALU_SRL: return r >> s[4:0];
      default: return r;
    endcase
  endfunction

  assign i_alu = alu_fn(o_alu_r, o_alu_s, o_alu_aluc);

  alu_arbiter #(.CNT_W(CW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req1_valid (i_req1_valid),
    .o_req0_ready (o_req0_ready),
    .o_req1_ready (o_req1_ready),
    .i_req0_r     (i_req0_r),
    .i_req0_s     (i_req0_s),
    .i_req1_r     (i_req1_r),
    .i_req1_s     (i_req1_s),
    .i_req0_aluc  (i_req0_aluc),
    .i_req1_aluc  (i_req1_aluc),
    .o_rsp0_valid (o_rsp0_valid),
    .o_rsp1_valid (o_rsp1_valid),
    .i_rsp0_ready (i_rsp0_ready),
    .i_rsp1_ready (i_rsp1_ready),
    .o_rsp_data   (o_rsp_data),
    .o_alu_r      (o_alu_r),
    .o_alu_s      (o_alu_s),
    .o_alu_aluc   (o_alu_aluc),
    .i_alu        (i_alu),
    .o_busy       (o_busy),
    .o_op_cnt     (o_op_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one held result slot plus a "who goes next" pointer.
  bit          m_held;
  int          m_owner;
  int          m_ptr;
  logic [31:0] m_data;
  int          m_cnt;
  int          last_g;
  logic        samp_rdy0, samp_rdy1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_data  = 32'd0;
    m_cnt   = 0;
  endtask

  // Called at posedge+1; asserts reset mid-cycle so the drop must be asynchronous.
  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk1("rst_rsp0_valid", o_rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", o_rsp1_valid, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk("rst_op_cnt", 32'(o_op_cnt), 32'd0);
    chk("rst_rsp_data", o_rsp_data, 32'd0);
    chk1("rst_ready0", o_req0_ready, 1'b0);
    chk1("rst_ready1", o_req1_ready, 1'b0);
    chk("rst_alu_r", o_alu_r, 32'd0);
    chk("rst_alu_s", o_alu_s, 32'd0);
    chk("rst_alu_aluc", 32'(o_alu_aluc), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  // One clock of traffic with the current inputs, checked against the model.
  task automatic cycle();
    bit          cons;
    int          g;
    logic [31:0] er, es;
    logic [3:0]  ec;
    cons = m_held && ((m_owner == 1) ? i_rsp1_ready : i_rsp0_ready);
    g = -1;
    if (!m_held || cons) begin
      if (i_req0_valid && i_req1_valid) g = m_ptr;
      else if (i_req0_valid)            g = 0;
      else if (i_req1_valid)            g = 1;
    end
    er = 32'd0; es = 32'd0; ec = 4'd0;
    if (g == 0) begin er = i_req0_r; es = i_req0_s; ec = i_req0_aluc; end
    if (g == 1) begin er = i_req1_r; es = i_req1_s; ec = i_req1_aluc; end

    @(negedge i_clk);
    samp_rdy0 = o_req0_ready;
    samp_rdy1 = o_req1_ready;
    chk1("ready0", o_req0_ready, g == 0);
    chk1("ready1", o_req1_ready, g == 1);
    chk("alu_r", o_alu_r, er);
    chk("alu_s", o_alu_s, es);
    chk("alu_aluc", 32'(o_alu_aluc), 32'(ec));

    @(posedge i_clk);
    if (cons) m_cnt = (m_cnt + 1) % (1 << CW);
    if (g >= 0) begin
      m_held  = 1'b1;
      m_owner = g;
      m_data  = alu_fn(er, es, ec);
      m_ptr   = 1 - g;
      $display("grant req%0d aluc=%0d r=%h s=%h result=%h", g, ec, er, es, m_data);
    end else if (cons) begin
      m_held = 1'b0;
    end
    last_g = g;

    #1;
    chk1("rsp0_valid", o_rsp0_valid, m_held && (m_owner == 0));
    chk1("rsp1_valid", o_rsp1_valid, m_held && (m_owner == 1));
    chk1("busy", o_busy, m_held);
    chk("op_cnt", 32'(o_op_cnt), 32'(m_cnt));
    if (m_held) chk("rsp_data", o_rsp_data, m_data);
  endtask

  typedef struct {
    bit          rst;
    bit          v0, v1, rr0, rr1;
    logic [31:0] r0, s0;
    logic [3:0]  c0;
    logic [31:0] r1, s1;
    logic [3:0]  c1;
    bit          e_rdy0, e_rdy1, e_v0, e_v1;
    logic [31:0] e_data;
    int          e_cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int prev;
    bit pend0, pend1;
    int cnt_before;

    i_rst = 1'b0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b0;
    i_req0_r = 32'd0; i_req0_s = 32'd0; i_req0_aluc = 4'd0;
    i_req1_r = 32'd0; i_req1_s = 32'd0; i_req1_aluc = 4'd0;
    last_g = -1;
    model_reset();

    // Contention from reset, then the single-operation case.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd10, 32'd3, ALU_SUB, 32'hF0, 32'h0F, ALU_OR,
               1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd10, 32'd3, ALU_SUB, 32'hF0, 32'h0F, ALU_OR,
               1'b0, 1'b1, 1'b0, 1'b1, 32'hFF, 1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, ALU_ADD,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, ALU_ADD,
               1'b1, 1'b0, 1'b1, 1'b0, 32'd12, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, ALU_ADD,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, ALU_ADD,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1};

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) begin
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        do_reset();
      end
      i_req0_valid = tbl[i].v0;  i_req1_valid = tbl[i].v1;
      i_rsp0_ready = tbl[i].rr0; i_rsp1_ready = tbl[i].rr1;
      i_req0_r = tbl[i].r0; i_req0_s = tbl[i].s0; i_req0_aluc = tbl[i].c0;
      i_req1_r = tbl[i].r1; i_req1_s = tbl[i].s1; i_req1_aluc = tbl[i].c1;
      cycle();
      chk1($sformatf("vec%0d_ready0", i), samp_rdy0, tbl[i].e_rdy0);
      chk1($sformatf("vec%0d_ready1", i), samp_rdy1, tbl[i].e_rdy1);
      chk1($sformatf("vec%0d_rsp0_valid", i), o_rsp0_valid, tbl[i].e_v0);
      chk1($sformatf("vec%0d_rsp1_valid", i), o_rsp1_valid, tbl[i].e_v1);
      chk($sformatf("vec%0d_op_cnt", i), 32'(o_op_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_v0 || tbl[i].e_v1)
        chk($sformatf("vec%0d_data", i), o_rsp_data, tbl[i].e_data);
    end

    // Backpressure: result held for four cycles while req1 waits.
    i_req0_valid = 1'b1; i_req1_valid = 1'b0;
    i_req0_r = 32'h1000; i_req0_s = 32'h234; i_req0_aluc = ALU_ADD;
    i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b1;
    cycle();
    chk("bp_data", o_rsp_data, 32'h1234);
    cnt_before = int'(o_op_cnt);
    i_req0_valid = 1'b0; i_req1_valid = 1'b1;
    i_req1_r = 32'hA5A5; i_req1_s = 32'h0F0F; i_req1_aluc = ALU_XOR;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk1("bp_no_ready1", samp_rdy1, 1'b0);
      chk1("bp_rsp0_valid", o_rsp0_valid, 1'b1);
      chk("bp_data_stable", o_rsp_data, 32'h1234);
      chk1("bp_busy", o_busy, 1'b1);
    end
    i_rsp0_ready = 1'b1;
    cycle();
    chk("bp_consume_cnt", 32'(o_op_cnt), 32'((cnt_before + 1) % (1 << CW)));
    chk1("bp_next_grant", samp_rdy1, 1'b1);
    i_req1_valid = 1'b0;
    cycle();

    // Fairness: both requesters always valid.
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk1("fair_granted", last_g >= 0, 1'b1);
      if (prev >= 0) chk("fair_alternate", 32'(last_g), 32'(1 - prev));
      prev = last_g;
      if (last_g == 0) begin i_req0_r = $urandom; i_req0_s = $urandom; i_req0_aluc = 4'($urandom_range(0, 7)); end
      if (last_g == 1) begin i_req1_r = $urandom; i_req1_s = $urandom; i_req1_aluc = 4'($urandom_range(0, 7)); end
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    cycle();

    // Reset while req1's result is held.
    do_reset();
    i_req0_valid = 1'b1; i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b0;
    i_req0_r = 32'd1; i_req0_s = 32'd2; i_req0_aluc = ALU_ADD;
    cycle();
    i_req0_valid = 1'b0; i_req1_valid = 1'b1;
    cycle();
    i_req1_valid = 1'b0;
    chk1("mid_hold_rsp1_valid", o_rsp1_valid, 1'b1);
    chk("mid_hold_cnt", 32'(o_op_cnt), 32'd1);
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    do_reset();
    // Leave the pointer at 1, reset, and expect req0 to win contention.
    i_req1_valid = 1'b0;
    cycle();
    i_req0_valid = 1'b0;
    do_reset();
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    cycle();
    chk1("ptr_reset_req0_wins", samp_rdy0, 1'b1);
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;

    // Counter wrap with a 4-bit counter.
    do_reset();
    i_req0_valid = 1'b1; i_rsp0_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      i_req0_r = $urandom; i_req0_s = $urandom; i_req0_aluc = 4'($urandom_range(0, 7));
      cycle();
      if (k == 15) chk("wrap_cnt15", 32'(o_op_cnt), 32'd15);
    end
    chk("wrap_cnt0", 32'(o_op_cnt), 32'd0);
    i_req0_valid = 1'b0;
    cycle();

    // Random traffic; requesters hold valid and operands until accepted.
    pend0 = 1'b0; pend1 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 60) == 0) do_reset();
      if (!pend0 && ($urandom_range(0, 1) == 1)) begin
        pend0 = 1'b1;
        i_req0_r = $urandom; i_req0_s = $urandom; i_req0_aluc = 4'($urandom_range(0, 7));
      end
      if (!pend1 && ($urandom_range(0, 1) == 1)) begin
        pend1 = 1'b1;
        i_req1_r = $urandom; i_req1_s = $urandom; i_req1_aluc = 4'($urandom_range(0, 7));
      end
      i_req0_valid = pend0; i_req1_valid = pend1;
      i_rsp0_ready = ($urandom_range(0, 3) != 0);
      i_rsp1_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_g == 0) pend0 = 1'b0;
      if (last_g == 1) pend1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
